// File: rtl/bcd_to_bin_serial.sv
// ----------------------------------------------------------------------------
// bcd_to_bin_serial
//
// Serial packed-BCD to binary converter using the reverse double-dabble method.
// The BCD operand and a binary accumulator form one long register that shifts
// right one bit per cycle. The bit leaving the BCD field enters the accumulator
// MSB. After every shift except the last, each BCD nibble that is >= 8 is
// reduced by 3. After BIN_W shifts the accumulator holds the binary value.
//
// Parameters
//   DIGITS : number of packed BCD digits on bcd_i (default 4)
//   BIN_W  : result width; must satisfy 2^BIN_W > 10^DIGITS - 1 (default 14)
//
// Ports
//   clk   in   single clock, rising edge
//   rst   in   synchronous, active-high reset
//   start in   request a conversion of bcd_i (sampled only while idle)
//   bcd_i in   packed BCD operand, digit 0 in bits [3:0]
//   bin_o out  binary result of the last completed conversion
//   busy  out  high while shifting and during the done cycle
//   done  out  one-cycle pulse; bin_o and err are valid while it is high
//   err   out  invalid-digit flag, valid with done
//
// Optional feature
//   BCD_DIGIT_CHECK_EN : when defined, a start whose operand contains a nibble
//   greater than 9 skips shifting. The block pulses done with err=1 on the
//   next cycle and leaves bin_o unchanged. When undefined, err is tied to 0.
// ----------------------------------------------------------------------------
module bcd_to_bin_serial #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_i,
    output logic [BIN_W-1:0]      bin_o,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]   r_acc;
    logic [BIN_W-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_last_shift;
    logic [BCD_W-1:0]   w_bcd_shift;
    logic [BCD_W-1:0]   w_bcd_corr;
    logic [BIN_W-1:0]   w_acc_shift;
    logic               w_bad_digit;

`ifdef BCD_DIGIT_CHECK_EN
    logic               r_err;

    always_comb begin
        w_bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_i[4*d +: 4] > 4'd9) begin
                w_bad_digit = 1'b1;
            end
        end
    end
`else
    assign w_bad_digit = 1'b0;
`endif

    // The counter holds the number of shifts already done. The shift
    // performed while it reads BIN_W-1 is the final one.
    assign w_last_shift = (r_cnt == CNT_W'(BIN_W - 1));

    // One step of the combined {BCD, accumulator} right shift.
    assign w_bcd_shift = r_bcd >> 1;
    assign w_acc_shift = {r_bcd[0], r_acc[BIN_W-1:1]};

    // Halving a decimal digit needs the nibble reduced by 3 whenever a 1 came
    // down from the digit above, which shows up as the nibble being >= 8.
    always_comb begin
        w_bcd_corr = w_bcd_shift;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_bcd_shift[4*d +: 4] >= 4'd8) begin
                w_bcd_corr[4*d +: 4] = w_bcd_shift[4*d +: 4] - 4'd3;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps every path assigned, so
    // no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_bad_digit ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_shift) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy  = (r_state != S_IDLE);
        done  = (r_state == S_DONE);
`ifdef BCD_DIGIT_CHECK_EN
        err   = done && r_err;
        // In the done cycle the accumulator is forwarded so the result is
        // valid alongside done. It is captured into r_bin as DONE exits.
        bin_o = (done && !r_err) ? r_acc : r_bin;
`else
        err   = 1'b0;
        bin_o = done ? r_acc : r_bin;
`endif
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd <= '0;
            r_acc <= '0;
            r_bin <= '0;
            r_cnt <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            r_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bcd <= bcd_i;
                        r_acc <= '0;
                        r_cnt <= '0;
`ifdef BCD_DIGIT_CHECK_EN
                        r_err <= w_bad_digit;
`endif
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_shift;
                    r_bcd <= w_last_shift ? w_bcd_shift : w_bcd_corr;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DONE: begin
`ifdef BCD_DIGIT_CHECK_EN
                    if (!r_err) begin
                        r_bin <= r_acc;
                    end
`else
                    r_bin <= r_acc;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// ----------------------------------------------------------------------------
// tb_bcd_to_bin_serial
//
// Self-checking bench for bcd_to_bin_serial with the default parameters
// (DIGITS=4, BIN_W=14). Expected results come from a decimal-value reference
// model. Latency is counted in rising edges from the edge that accepts start.
// Inputs are driven and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_bcd_to_bin_serial;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int LAT    = BIN_W + 1;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [4*DIGITS-1:0]  bcd_i;
    logic [BIN_W-1:0]     bin_o;
    logic                 busy;
    logic                 done;
    logic                 err;

    int n_vec;
    int n_err;

    bcd_to_bin_serial #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd_i (bcd_i),
        .bin_o (bin_o),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: the decimal value of a packed BCD word.
    function automatic int bcd_value(input logic [4*DIGITS-1:0] b);
        int v;
        int w;
        v = 0;
        w = 1;
        for (int d = 0; d < DIGITS; d++) begin
            v += int'(b[4*d +: 4]) * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic logic [4*DIGITS-1:0] rand_bcd();
        logic [4*DIGITS-1:0] b;
        for (int d = 0; d < DIGITS; d++) begin
            b[4*d +: 4] = 4'($urandom_range(0, 9));
        end
        return b;
    endfunction

    // Pulses start for one cycle and waits (bounded) for done. lat is the
    // number of rising edges from the accepting edge up to and including the
    // edge that raised done. busy_cnt is the number of those cycles with busy=1.
    task automatic convert(input logic [4*DIGITS-1:0] b, output int lat, output int busy_cnt);
        bcd_i    = b;
        start    = 1'b1;
        lat      = 0;
        busy_cnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) busy_cnt++;
            if (done) break;
        end
    endtask

    // Full valid conversion with all the usual checks.
    task automatic run_valid(input string tag, input logic [4*DIGITS-1:0] b);
        int lat;
        int bc;
        convert(b, lat, bc);
        check({tag, "_lat"},  lat, LAT);
        check({tag, "_bin"},  32'(bin_o), bcd_value(b));
        check({tag, "_err"},  32'(err), 0);
        check({tag, "_busy"}, bc, LAT);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 0);
        check({tag, "_idle"},  32'(busy), 0);
        check({tag, "_hold"},  32'(bin_o), bcd_value(b));
    endtask

    initial begin
        int lat;
        int bc;
        int ndone;
        int first;
        int dones [2];
        logic [31:0] seen_bin;
        logic [31:0] seen_bin2;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        bcd_i = '0;

        // Reset state, with start asserted to confirm reset has priority.
        @(negedge clk);
        start = 1'b1;
        bcd_i = 16'h1234;
        repeat (2) @(negedge clk);
        check("rst_bin",  32'(bin_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err",  32'(err), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("rst_idle", 32'(busy), 0);

        // Directed values, including both ends of the range.
        run_valid("c1234", 16'h1234);
        run_valid("c9999", 16'h9999);
        run_valid("c0000", 16'h0000);
        run_valid("c0001", 16'h0001);
        run_valid("c0080", 16'h0080);

        // A second start while busy must be neither honoured nor queued.
        bcd_i = 16'h0042;
        start = 1'b1;
        ndone = 0;
        first = -1;
        seen_bin = '0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            start = (i == 5);
            bcd_i = (i == 5) ? 16'h0777 : 16'h0042;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first    = i;
                    seen_bin = 32'(bin_o);
                end
            end
        end
        start = 1'b0;
        check("busy_start_ndone", ndone, 1);
        check("busy_start_lat",   first, LAT);
        check("busy_start_bin",   seen_bin, 42);

        // Reset in the middle of a conversion aborts it and clears bin_o.
        run_valid("c0500", 16'h0500);
        bcd_i = 16'h0999;
        start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = (i == 7);
            if (done) ndone++;
        end
        check("abort_ndone", ndone, 0);
        check("abort_bin",   32'(bin_o), 0);
        check("abort_busy",  32'(busy), 0);
        run_valid("c0008", 16'h0008);

        // start held high restarts on the first idle cycle after each done.
        // The second operand is applied mid-conversion and must be latched
        // only on the restart.
        bcd_i     = 16'h0321;
        start     = 1'b1;
        ndone     = 0;
        dones[0]  = -1;
        dones[1]  = -1;
        seen_bin  = '0;
        seen_bin2 = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 3) bcd_i = 16'h0654;
            if (done) begin
                if (ndone == 0) seen_bin  = 32'(bin_o);
                else            seen_bin2 = 32'(bin_o);
                if (ndone < 2) dones[ndone] = i;
                ndone++;
                if (ndone == 2) break;
            end
        end
        start = 1'b0;
        check("held_first_lat", dones[0], LAT);
        check("held_gap",       dones[1] - dones[0], LAT + 1);
        check("held_bin1",      seen_bin, 321);
        check("held_bin2",      seen_bin2, 654);
        @(negedge clk);

        // Invalid digit behaviour depends on the optional check.
        run_valid("c1234b", 16'h1234);
        convert(16'h12A4, lat, bc);
`ifdef BCD_DIGIT_CHECK_EN
        check("bad_lat", lat, 1);
        check("bad_err", 32'(err), 1);
        check("bad_bin", 32'(bin_o), 1234);
        @(negedge clk);
        check("bad_hold", 32'(bin_o), 1234);
`else
        check("bad_lat", lat, LAT);
        check("bad_err", 32'(err), 0);
        @(negedge clk);
`endif
        run_valid("after_bad", 16'h0057);

        // Randomized valid operands.
        for (int k = 0; k < 25; k++) begin
            logic [4*DIGITS-1:0] b;
            b = rand_bcd();
            convert(b, lat, bc);
            check("rnd_lat", lat, LAT);
            check("rnd_bin", 32'(bin_o), bcd_value(b));
            check("rnd_err", 32'(err), 0);
            @(negedge clk);
            check("rnd_pulse", 32'(done), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_serial.md
BCD_TO_BIN_SERIAL -- requirements
Module: bcd_to_bin_serial

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of packed BCD digits on bcd_i.
REQ-002 SHALL have parameter BIN_W, default 14, width of bin_o; legal only when 2^BIN_W > 10^DIGITS - 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request conversion of bcd_i; sampled only in IDLE.
REQ-006 SHALL have port bcd_i  input  4*DIGITS  packed BCD operand, digit 0 in bits [3:0].
REQ-007 SHALL have port bin_o  output  BIN_W  binary result of the last completed conversion.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  single-cycle pulse; bin_o and err are valid when high.
REQ-010 SHALL have port err  output  1  invalid-digit flag, valid with done.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1: SHALL latch bcd_i into an internal 4*DIGITS BCD register, clear the BIN_W shift accumulator and the iteration counter, and go to SHIFT.
REQ-013 IDLE with start=0: SHALL stay in IDLE; bcd_i changes are ignored.
REQ-014 Each SHIFT cycle: SHALL shift {BCD reg, accumulator} right by 1 (BCD LSB enters accumulator MSB), then subtract 3 from every BCD nibble >= 8, and increment the counter.
REQ-015 SHALL skip the nibble correction on the final (BIN_W-th) shift and go to DONE.
REQ-016 SHALL spend exactly BIN_W cycles in SHIFT.
REQ-017 DONE: SHALL load bin_o from the accumulator, assert done for exactly one cycle, and return to IDLE next cycle.
REQ-018 Latency: done SHALL be high in the cycle that starts BIN_W+1 rising edges after the edge that sampled start, which is 15 cycles for the defaults.
REQ-019 bin_o SHALL hold its value between completions; it SHALL change only in DONE.
REQ-020 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-021 start asserted while busy=1, including in the DONE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-022 start held high continuously SHALL begin a new conversion on the first IDLE cycle after each DONE.
REQ-023 For valid input the result SHALL equal the decimal value of bcd_i: 0 maps to 0, and all-nines maps to 10^DIGITS - 1.
REQ-024 err SHALL be 0 whenever the configuration feature is compiled out.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE and clear the counter, internal registers, bin_o, busy, done and err to 0.
REQ-026 rst asserted mid-conversion SHALL abort the conversion with no done pulse, and bin_o SHALL read 0.
REQ-027 rst SHALL take priority over start in the same cycle.

Configuration
REQ-028 Macro BCD_DIGIT_CHECK_EN defined: on start acceptance, if any nibble of bcd_i is > 9, the block SHALL go directly from IDLE to DONE without shifting.
REQ-029 In that invalid-digit case the block SHALL pulse done with err=1 one cycle after the start edge and SHALL leave bin_o unchanged; err SHALL be 0 on valid conversions.
REQ-030 Macro BCD_DIGIT_CHECK_EN undefined: the block SHALL have no digit check, SHALL tie err to 0, and every start SHALL take the full REQ-018 latency; results for invalid digits are unspecified.

Verification
REQ-031 bcd_i=16'h1234, start for 1 cycle -> done exactly 15 cycles later, bin_o=14'd1234 (0x04D2), err=0, busy high for 15 cycles.
REQ-032 bcd_i=16'h9999 -> bin_o=9999 (0x270F); then bcd_i=16'h0000 -> bin_o=0; each done is one cycle wide.
REQ-033 start at cycle 0 with bcd_i=16'h0042, second start at cycle 5 with bcd_i=16'h0777 -> exactly one done, at cycle 15, with bin_o=42.
REQ-034 Convert 16'h0500 (bin_o=500), start 16'h0999, assert rst at cycle 7 -> no done, bin_o=0, busy=0; the next start with 16'h0008 -> bin_o=8.
REQ-035 With BCD_DIGIT_CHECK_EN: bin_o=1234, then bcd_i=16'h12A4 -> done at cycle 1, err=1, bin_o still 1234; without the macro -> done at cycle 15, err=0.
